// File: rtl/uio_bus_arb_pkg.sv
// vc_uio_pkg: shared types and constants for the uio pin-bank arbiter.
package vc_uio_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1, ARB_TURN} arb_state_e;
  localparam logic UIO_REQ_CPU = 1'b0;
  localparam logic UIO_REQ_DBG = 1'b1;
  localparam int UIO_TURN_DEFAULT = 2;
  // Round robin: on contention the requester that did not own last wins.
  function automatic arb_state_e uio_pick(logic r0, logic r1, logic last);
    return (r0 && (!r1 || last == UIO_REQ_DBG)) ? ARB_OWN0 : r1 ? ARB_OWN1 : ARB_IDLE;
  endfunction
endpackage

// File: rtl/uio_arb_timer.sv
// uio_arb_timer: loadable saturating down-counter with an expiry flag.
module uio_arb_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         exp_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = ld_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign exp_o = cnt_q == '0;
endmodule

// File: rtl/uio_bus_arb.sv
// uio_bus_arb: two-requester owner sequencer for the uio pin bank with turnaround and watchdog.
module uio_bus_arb
  import vc_uio_pkg::*;
#(
  parameter logic [15:0] HOLD_MAX    = 16'd1024,
  parameter int          TURN_CYCLES = UIO_TURN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       done0,
  input  logic [7:0] out0,
  input  logic [7:0] oe0,
  output logic       gnt0,
  input  logic       req1,
  input  logic       done1,
  input  logic [7:0] out1,
  input  logic [7:0] oe1,
  output logic       gnt1,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       busy,
  output logic       timeout,
  output logic       timeout_id
);
  arb_state_e state_q, state_d, pick;
  logic last_q, last_d, to_q, to_d, tid_q, tid_d;
  logic own, id, rel, wd, leave, enter, hold_exp, turn_exp;
  always_comb begin
    own   = state_q == ARB_OWN0 || state_q == ARB_OWN1;
    id    = state_q == ARB_OWN1;
    rel   = own && ((id ? done1 : done0) || !(id ? req1 : req0));
    // A done or dropped request on the expiry cycle wins over the watchdog.
    wd    = own && hold_exp && !rel;
    leave = rel || wd;
    pick  = uio_pick(req0, req1, last_q);
    state_d = state_q == ARB_IDLE ? pick :
              own ? (leave ? ARB_TURN : state_q) :
              turn_exp ? pick : ARB_TURN;
    enter  = !own && (state_d == ARB_OWN0 || state_d == ARB_OWN1);
    last_d = leave ? id : last_q;
    to_d   = wd;
    tid_d  = wd & id;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= UIO_REQ_DBG;
      to_q    <= 1'b0;
      tid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      to_q    <= to_d;
      tid_q   <= tid_d;
    end
  uio_arb_timer #(.W(16)) u_hold (
    .clk(clk), .reset(reset), .ld_i(enter || leave),
    .val_i(enter ? HOLD_MAX - 16'd1 : 16'd0), .en_i(own), .exp_o(hold_exp)
  );
  uio_arb_timer #(.W(4)) u_turn (
    .clk(clk), .reset(reset), .ld_i(leave),
    .val_i(4'(TURN_CYCLES - 1)), .en_i(state_q == ARB_TURN), .exp_o(turn_exp)
  );
  assign gnt0       = state_q == ARB_OWN0;
  assign gnt1       = state_q == ARB_OWN1;
  assign busy       = state_q != ARB_IDLE;
  assign uio_out    = gnt0 ? out0 : gnt1 ? out1 : 8'h00;
  assign uio_oe     = gnt0 ? oe0 : gnt1 ? oe1 : 8'h00;
  assign timeout    = to_q;
  assign timeout_id = tid_q;
endmodule

// File: tb/tb_uio_bus_arb.sv
// tb_uio_bus_arb: vector table of per-cycle inputs/expected flags checked through a scoreboard queue.
module tb_uio_bus_arb;
  logic clk = 1'b0;
  logic reset = 1'b1, req0 = 1'b0, done0 = 1'b0, req1 = 1'b0, done1 = 1'b0;
  logic [7:0] out0 = 8'hA5, oe0 = 8'h0F, out1 = 8'h3C, oe1 = 8'hF0;
  logic gnt0, gnt1, busy, timeout, timeout_id;
  logic [7:0] uio_out, uio_oe;
  logic finished = 1'b0;
  always #5 clk = ~clk;
  uio_bus_arb #(.HOLD_MAX(16'd16), .TURN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .done0(done0), .out0(out0), .oe0(oe0), .gnt0(gnt0),
    .req1(req1), .done1(done1), .out1(out1), .oe1(oe1), .gnt1(gnt1),
    .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy),
    .timeout(timeout), .timeout_id(timeout_id)
  );
  typedef struct {
    string      n;
    logic [4:0] in;
    logic [4:0] ex;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int pass = 0, total = 0;
  localparam logic [4:0] IDLE = 5'b00000, OWN0 = 5'b10100, OWN1 = 5'b01100, TURN = 5'b00100;
  task automatic s(input string n, input logic [4:0] in, input logic [4:0] ex);
    vec_t v;
    v.n = n;
    v.in = in;
    v.ex = ex;
    tbl.push_back(v);
  endtask
  function automatic logic [20:0] full(input logic [4:0] ex);
    return {ex, ex[4] ? 8'hA5 : ex[3] ? 8'h3C : 8'h00, ex[4] ? 8'h0F : ex[3] ? 8'hF0 : 8'h00};
  endfunction
  initial begin
    #100000;
    if (!finished) begin
      $display("FAIL expired wait: simulation did not complete in time");
      $finish;
    end
  end
  initial begin
    vec_t v;
    logic [20:0] act, exp;
    s("reset", 5'b10000, IDLE); s("reset2", 5'b10000, IDLE);
    s("grant0", 5'b01000, OWN0);
    repeat (2) s("hold0", 5'b01000, OWN0);
    s("req1_ignored", 5'b01010, OWN0);
    s("done0_turn1", 5'b01110, TURN);
    s("turn2", 5'b00010, TURN);
    s("regrant1", 5'b00010, OWN1);
    s("nonowner_done0", 5'b00110, OWN1);
    s("done1_turn1", 5'b00011, TURN);
    s("turn2_noreq", 5'b00000, TURN);
    s("to_idle", 5'b00000, IDLE);
    s("idle_done_ignored", 5'b00101, IDLE);
    s("reset_rr", 5'b10000, IDLE);
    s("rr_first0", 5'b01010, OWN0);
    for (int i = 0; i < 4; i++) begin
      repeat (4) s("rr_hold", 5'b01010, i % 2 ? OWN1 : OWN0);
      s("rr_done", i % 2 ? 5'b01011 : 5'b01110, TURN);
      s("rr_turn", 5'b01010, TURN);
      s("rr_next", 5'b01010, i % 2 ? OWN0 : OWN1);
    end
    s("drop0_turn1", 5'b00000, TURN);
    s("drop0_turn2", 5'b00000, TURN);
    s("drop0_idle", 5'b00000, IDLE);
    s("wd1_grant", 5'b00010, OWN1);
    repeat (15) s("wd1_hold", 5'b00010, OWN1);
    s("wd1_expire", 5'b00010, 5'b00111);
    s("wd1_pulse_gone", 5'b00010, TURN);
    s("wd1_regrant", 5'b00010, OWN1);
    s("drop1_turn1", 5'b00000, TURN);
    s("drop1_turn2", 5'b01000, TURN);
    s("wd0_grant", 5'b01000, OWN0);
    repeat (14) s("wd0_hold", 5'b01000, OWN0);
    s("nonowner_done1", 5'b01001, OWN0);
    s("done0_at_expiry", 5'b01100, TURN);
    s("no_timeout", 5'b00000, TURN);
    s("wd0_idle", 5'b00000, IDLE);
    s("mid_grant1", 5'b00010, OWN1);
    repeat (15) s("mid_hold1", 5'b00010, OWN1);
    s("reset_mid_own1", 5'b10010, IDLE);
    s("after_reset", 5'b00000, IDLE);
    foreach (tbl[i]) begin
      @(negedge clk);
      {reset, req0, done0, req1, done1} = tbl[i].in;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      v = sb.pop_front();
      act = {gnt0, gnt1, busy, timeout, timeout_id & timeout, uio_out, uio_oe};
      exp = full(v.ex);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s (vec %0d): got flags=%b out=%h oe=%h, want flags=%b out=%h oe=%h",
                    v.n, i, act[20:16], act[15:8], act[7:0], exp[20:16], exp[15:8], exp[7:0]);
      if (v.in[4]) begin
        total++;
        if ({gnt0, gnt1, busy, timeout, timeout_id, uio_out, uio_oe} === 21'd0) pass++;
        else $display("FAIL reset state (vec %0d): gnt0=%b gnt1=%b busy=%b timeout=%b timeout_id=%b out=%h oe=%h",
                      i, gnt0, gnt1, busy, timeout, timeout_id, uio_out, uio_oe);
      end
    end
    finished = 1'b1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
